// File: rtl/fetch_sequencer_if.sv
// Handshake and bus bundle for fetch_sequencer: PC stream, PC update command,
// instruction memory, execute redirect and decode output.
interface fetch_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_pc_valid;
    logic [XLEN-1:0] i_pc_data;
    logic            o_incr_valid;
    logic            i_incr_ready;
    logic [1:0]      o_incr_op;
    logic [XLEN-1:0] o_incr_data;
    logic            o_imem_req_valid;
    logic            i_imem_req_ready;
    logic [XLEN-1:0] o_imem_req_addr;
    logic            i_imem_rsp_valid;
    logic [31:0]     i_imem_rsp_data;
    logic            i_redir_valid;
    logic [1:0]      i_redir_op;
    logic [XLEN-1:0] i_redir_data;
    logic            o_inst_valid;
    logic            i_inst_ready;
    logic [31:0]     o_inst_data;
    logic [XLEN-1:0] o_inst_pc;
    logic            o_misalign_err;

    modport slave (
        input  i_pc_valid, i_pc_data, i_incr_ready, i_imem_req_ready,
        input  i_imem_rsp_valid, i_imem_rsp_data, i_redir_valid, i_redir_op,
        input  i_redir_data, i_inst_ready,
        output o_incr_valid, o_incr_op, o_incr_data, o_imem_req_valid,
        output o_imem_req_addr, o_inst_valid, o_inst_data, o_inst_pc,
        output o_misalign_err
    );

    modport master (
        output i_pc_valid, i_pc_data, i_incr_ready, i_imem_req_ready,
        output i_imem_rsp_valid, i_imem_rsp_data, i_redir_valid, i_redir_op,
        output i_redir_data, i_inst_ready,
        input  o_incr_valid, o_incr_op, o_incr_data, o_imem_req_valid,
        input  o_imem_req_addr, o_inst_valid, o_inst_data, o_inst_pc,
        input  o_misalign_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-issue, non-pipelined instruction fetch sequencer.
// Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned PCs into a sticky ERR state.
module fetch_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic              clk,
    input logic              rst,
    fetch_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_UPD,
        S_SETTLE,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic            r_pend_valid;
    logic [1:0]      r_pend_op;
    logic [XLEN-1:0] r_pend_data;
    logic            w_redir;
    logic            w_pend_any;
    logic            w_misalign;

    assign w_redir    = bus.i_redir_valid && ((bus.i_redir_op == 2'b01) || (bus.i_redir_op == 2'b10));
    // A redirect landing in the response cycle also kills the word.
    assign w_pend_any = r_pend_valid || w_redir;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_err;

    assign w_misalign         = |bus.i_pc_data[1:0];
    assign bus.o_misalign_err = r_err;
    assign bus.o_imem_req_addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && bus.i_pc_valid && w_misalign) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_misalign          = 1'b0;
    assign bus.o_misalign_err  = 1'b0;
    assign bus.o_imem_req_addr = {r_pc[XLEN-1:2], 2'b00};
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.i_pc_valid) w_next = w_misalign ? S_ERR : S_REQ;
            S_REQ:    if (bus.i_imem_req_ready) w_next = S_WAIT;
            S_WAIT:   if (bus.i_imem_rsp_valid) w_next = w_pend_any ? S_UPD : S_OUT;
            S_OUT:    if (bus.i_inst_ready || w_redir) w_next = S_UPD;
            S_UPD:    if (bus.i_incr_ready) w_next = S_SETTLE;
            S_SETTLE: w_next = S_IDLE;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_inst       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_op    <= '0;
            r_pend_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.i_pc_valid) begin
                r_pc <= bus.i_pc_data;
            end
            if (r_state == S_WAIT && bus.i_imem_rsp_valid) begin
                r_inst <= bus.i_imem_rsp_data;
            end
            // A fresh redirect wins over clearing the one just issued.
            if (w_redir) begin
                r_pend_valid <= 1'b1;
                r_pend_op    <= bus.i_redir_op;
                r_pend_data  <= bus.i_redir_data;
            end else if (r_state == S_UPD && bus.i_incr_ready && r_pend_valid) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign bus.o_imem_req_valid = (r_state == S_REQ);
    assign bus.o_inst_valid     = (r_state == S_OUT);
    assign bus.o_inst_data      = r_inst;
    assign bus.o_inst_pc        = r_pc;
    assign bus.o_incr_valid     = (r_state == S_UPD);
    assign bus.o_incr_op        = (r_state == S_UPD && r_pend_valid) ? r_pend_op : 2'b00;
    assign bus.o_incr_data      = (r_state == S_UPD && r_pend_valid) ? r_pend_data : '0;
endmodule
